hex_display_decoder: RTL

HEX_DISPLAY_DECODER -- requirements
Module: hex_display_decoder

---
 rtl/hex_display_decoder_if.sv | 30 +++
 rtl/hex_display_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hex_display_decoder_if.sv
// Bus bundle for hex_display_decoder.
//   hexleds   : 42-bit active-low seven-segment input, digit k on [7k+6:7k], seg a = bit 0
//   out_value : 24-bit decoded value, digit k on [4k+3:4k]
//   out_bad   : per-digit flag, 1 = segment pattern not recognised
//   out_valid : published frame available
//   out_ready : consumer accepts the frame when high together with out_valid
// master = environment (display source + consumer), slave = decoder.
interface hex_display_decoder_if;
  logic [41:0] hexleds;
  logic [23:0] out_value;
  logic [5:0]  out_bad;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output hexleds,
    output out_ready,
    input  out_value,
    input  out_bad,
    input  out_valid
  );

  modport slave (
    input  hexleds,
    input  out_ready,
    output out_value,
    output out_bad,
    output out_valid
  );
endinterface

// File: rtl/hex_display_decoder.sv
// Six-digit seven-segment display scraper. Snapshots the segment bus, decodes one digit per
// cycle, and publishes a frame over a valid/ready handshake once STABLE_FRAMES identical
// consecutive frames have been seen and the frame differs from the last one published.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : hex_display_decoder_if.slave (hexleds in, out_value/out_bad/out_valid out,
//             out_ready in)
// Parameter STABLE_FRAMES (1..15): identical frames required before publishing.
// Build option: define HEX_DISPLAY_DECODER_BLANK_EN to accept the all-off pattern (7F) as a
// valid blank digit (nibble 0, bad = 0); otherwise it is flagged bad.
module hex_display_decoder #(
  parameter int unsigned STABLE_FRAMES = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  hex_display_decoder_if.slave bus
);

  localparam logic [3:0] StableMax = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {StCapture, StDecode, StCompare, StOffer} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  count_q, count_d;
  logic        published_q, published_d;
  logic [41:0] snap_q, snap_d;
  logic [23:0] cur_value_q, cur_value_d;
  logic [5:0]  cur_bad_q, cur_bad_d;
  logic [23:0] prev_value_q, prev_value_d;
  logic [5:0]  prev_bad_q, prev_bad_d;
  logic [23:0] out_value_q, out_value_d;
  logic [5:0]  out_bad_q, out_bad_d;
  logic        out_valid_q, out_valid_d;

  logic [6:0]  seg_sel;
  logic [4:0]  dec;

  // Returns {bad, nibble}.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h18:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
`ifdef HEX_DISPLAY_DECODER_BLANK_EN
      7'h7F:   r = 5'h00;
`endif
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    seg_sel = snap_q[6:0];
    for (int k = 0; k < 6; k++) begin
      if (idx_q == 3'(k)) seg_sel = snap_q[7*k +: 7];
    end
    dec = decode_seg(seg_sel);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    published_d  = published_q;
    snap_d       = snap_q;
    cur_value_d  = cur_value_q;
    cur_bad_d    = cur_bad_q;
    prev_value_d = prev_value_q;
    prev_bad_d   = prev_bad_q;
    out_value_d  = out_value_q;
    out_bad_d    = out_bad_q;
    out_valid_d  = out_valid_q;

    unique case (state_q)
      StCapture: begin
        snap_d  = bus.hexleds;
        idx_d   = 3'd0;
        state_d = StDecode;
      end
      StDecode: begin
        for (int k = 0; k < 6; k++) begin
          if (idx_q == 3'(k)) begin
            cur_value_d[4*k +: 4] = dec[3:0];
            cur_bad_d[k]          = dec[4];
          end
        end
        if (idx_q == 3'd5) begin
          idx_d   = 3'd0;
          state_d = StCompare;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StCompare: begin
        if ({cur_value_q, cur_bad_q} == {prev_value_q, prev_bad_q}) begin
          if (count_q < StableMax) count_d = count_q + 4'd1;
        end else begin
          prev_value_d = cur_value_q;
          prev_bad_d   = cur_bad_q;
          count_d      = 4'd1;
        end
        // The output registers only change on entry to offer and always complete a handshake
        // before leaving it, so they double as the last-published frame.
        if (count_d == StableMax &&
            (!published_q || {cur_value_q, cur_bad_q} != {out_value_q, out_bad_q})) begin
          out_value_d = cur_value_q;
          out_bad_d   = cur_bad_q;
          out_valid_d = 1'b1;
          state_d     = StOffer;
        end else begin
          state_d = StCapture;
        end
      end
      StOffer: begin
        if (out_valid_q && bus.out_ready) begin
          published_d = 1'b1;
          out_valid_d = 1'b0;
          state_d     = StCapture;
        end
      end
      default: state_d = StCapture;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StCapture;
      idx_q        <= 3'd0;
      count_q      <= 4'd0;
      published_q  <= 1'b0;
      snap_q       <= '0;
      cur_value_q  <= '0;
      cur_bad_q    <= '0;
      prev_value_q <= '0;
      prev_bad_q   <= '0;
      out_value_q  <= '0;
      out_bad_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      published_q  <= published_d;
      snap_q       <= snap_d;
      cur_value_q  <= cur_value_d;
      cur_bad_q    <= cur_bad_d;
      prev_value_q <= prev_value_d;
      prev_bad_q   <= prev_bad_d;
      out_value_q  <= out_value_d;
      out_bad_q    <= out_bad_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.out_value = out_value_q;
  assign bus.out_bad   = out_bad_q;
  assign bus.out_valid = out_valid_q;

endmodule
